inst_prefetch_queue: RTL and testbench

- Instruction prefetcher between the instruction memory bus and the fetch stage of the 5-stage MIPS pipeline.
- Owns the architectural fetch PC and issues in-order word reads to imem ahead of demand.
- Buffers returned words with their pc+4 in a small FIFO that the F/D register drains, and flushes on branch/jump redirect from decode.

---
 rtl/inst_prefetch_queue_pkg.sv | 12 +
 rtl/inst_prefetch_queue_if.sv | 26 ++
 rtl/inst_prefetch_queue_sync_fifo.sv | 47 ++++
 rtl/inst_prefetch_queue.sv | 100 ++++++++++
 tb/tb_inst_prefetch_queue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_pkg;

    localparam int          WORD_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc_plus4;
    } inst_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle: decode redirect, F/D dequeue port and the imem request/response bus.
interface inst_prefetch_queue_if;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc_plus4;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        input  redirect, redirect_pc, deq_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
        output deq_valid, deq_inst, deq_pc_plus4, mem_req_valid, mem_req_addr
    );

    modport slave (
        output redirect, redirect_pc, deq_ready, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  deq_valid, deq_inst, deq_pc_plus4, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/inst_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Clear discards contents without moving the write side, so pointers stay consistent.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    a_no_overflow:  assert property (@(posedge clk) disable iff (reset) (push && !clear) |-> (count != CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) (pop && !clear) |-> (count != '0));

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetcher: owns fetch PC, issues in-order imem reads, buffers words for F/D.
// Optional zero-latency response bypass when built with PREFETCH_BYPASS_EN defined.
module inst_prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    inst_prefetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW:0]   in_flight;
    logic          issue_hs;
    logic          resp_accept;
    logic          has_head;
    logic          bypass_take;
    logic          data_push;
    logic          data_pop;
    logic [31:0]   tag_head;
    logic [63:0]   data_rd;
    inst_entry_t   head_entry;
    inst_entry_t   resp_entry;
    inst_entry_t   deq_entry;

    // Credits cover both buffered words and reads still in flight, so the FIFO can never overflow.
    assign in_flight         = {1'b0, count} + {1'b0, outstanding};
    assign bus.mem_req_valid = !reset && !bus.redirect && (in_flight < (CW+1)'(DEPTH));
    assign bus.mem_req_addr  = fetch_pc;
    assign issue_hs          = bus.mem_req_valid && bus.mem_req_ready;
    assign resp_accept       = bus.mem_resp_valid && (outstanding != '0);

    assign head_entry = data_rd;
    assign resp_entry = '{inst: bus.mem_resp_data, pc_plus4: tag_head};
    assign has_head   = (count != '0);

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass        = !has_head && (drop == '0) && !bus.redirect && resp_accept;
    assign bus.deq_valid = has_head || bypass;
    assign deq_entry     = has_head ? head_entry : (bypass ? resp_entry : '0);
    assign bypass_take   = bypass && bus.deq_ready;
`else
    assign bus.deq_valid = has_head;
    assign deq_entry     = has_head ? head_entry : '0;
    assign bypass_take   = 1'b0;
`endif

    assign bus.deq_inst     = deq_entry.inst;
    assign bus.deq_pc_plus4 = deq_entry.pc_plus4;

    assign data_push = resp_accept && (drop == '0) && !bus.redirect && !bypass_take;
    assign data_pop  = has_head && bus.deq_ready && !bus.redirect;

    // A redirect marks every read still in flight after this edge as stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop     <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            drop     <= outstanding - CW'(resp_accept);
        end else begin
            if (issue_hs) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
            if (resp_accept && (drop != '0)) drop <= drop - 1'b1;
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (1'b0),
        .push    (issue_hs),
        .pop     (resp_accept),
        .wr_data (fetch_pc + 32'(WORD_BYTES)),
        .rd_data (tag_head),
        .count   (outstanding)
    );

    sync_fifo #(.WIDTH($bits(inst_entry_t)), .DEPTH(DEPTH)) u_data_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (bus.redirect),
        .push    (data_push),
        .pop     (data_pop),
        .wr_data (resp_entry),
        .rd_data (data_rd),
        .count   (count)
    );

    a_resp_has_request: assert property (@(posedge clk) disable iff (reset) bus.mem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomised self-checking bench for inst_prefetch_queue with a queue-level reference model.
module tb_inst_prefetch_queue;
    import prefetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = RESET_PC_DEFAULT;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_prefetch_queue_if bus();

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model: fetch PC, addresses in flight, buffered entries, stale-response count.
    bit          model_valid = 1'b0;
    logic [31:0] m_fetch;
    logic [31:0] m_out[$];
    inst_entry_t m_buf[$];
    int          m_drop;

    // Memory responder: in-order queue of accepted addresses and the cycle each may return.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          mem_lat      = 1;
    bit          mem_stall_en = 1'b0;
    int          hs_count     = 0;

    logic        e_req_valid, e_deq_valid, e_bypass;
    logic [31:0] e_req_addr, e_inst, e_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2402_0005;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    task automatic checkOutput();
        if (!model_valid) return;
        e_req_valid = !reset && !bus.redirect && ((m_buf.size() + m_out.size()) < DEPTH);
        e_req_addr  = m_fetch;
        e_bypass    = BYP && (m_buf.size() == 0) && (m_drop == 0) && !bus.redirect
                      && bus.mem_resp_valid && (m_out.size() > 0);
        if (m_buf.size() > 0) begin
            e_deq_valid = 1'b1;
            e_inst      = m_buf[0].inst;
            e_pc4       = m_buf[0].pc_plus4;
        end else if (e_bypass) begin
            e_deq_valid = 1'b1;
            e_inst      = mem_word(m_out[0]);
            e_pc4       = m_out[0] + 32'd4;
        end else begin
            e_deq_valid = 1'b0;
            e_inst      = 32'h0;
            e_pc4       = 32'h0;
        end
        cmp("mem_req_valid", 32'(bus.mem_req_valid), 32'(e_req_valid));
        cmp("mem_req_addr",  bus.mem_req_addr, e_req_addr);
        cmp("deq_valid",     32'(bus.deq_valid), 32'(e_deq_valid));
        cmp("deq_inst",      bus.deq_inst, e_inst);
        cmp("deq_pc_plus4",  bus.deq_pc_plus4, e_pc4);
    endtask

    task automatic modelStep(input logic rst, input logic rdr, input logic [31:0] rpc,
                             input logic rq_rdy, input logic dq_rdy, input logic resp_v);
        logic [31:0] a;
        bit          resp_acc;
        if (rst) begin
            m_fetch = RESET_PC;
            m_out.delete();
            m_buf.delete();
            m_drop      = 0;
            model_valid = 1'b1;
            return;
        end
        resp_acc = resp_v && (m_out.size() > 0);
        a = 32'h0;
        if (resp_acc) a = m_out.pop_front();
        if (rdr) begin
            m_fetch = rpc;
            m_buf.delete();
            m_drop = m_out.size();
        end else begin
            if (e_deq_valid && dq_rdy && (m_buf.size() > 0)) void'(m_buf.pop_front());
            if (resp_acc) begin
                if (m_drop > 0) m_drop--;
                else if (!(e_bypass && dq_rdy)) m_buf.push_back('{inst: mem_word(a), pc_plus4: a + 32'd4});
            end
            if (e_req_valid && rq_rdy) begin
                m_out.push_back(m_fetch);
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdr, input logic [31:0] rpc,
                                 input logic rq_rdy, input logic dq_rdy);
        @(negedge clk);
        reset             = rst;
        bus.redirect      = rdr;
        bus.redirect_pc   = rpc;
        bus.mem_req_ready = rq_rdy;
        bus.deq_ready     = dq_rdy;
        if (!rst && (mem_addr_q.size() > 0) && (mem_due_q[0] <= cycle)
            && (!mem_stall_en || ($urandom_range(0, 3) != 0))) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_word(mem_addr_q[0]);
        end else begin
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = $urandom;
        end
        #1;
        checkOutput();
        modelStep(rst, rdr, rpc, rq_rdy, dq_rdy, bus.mem_resp_valid);
        if (rst) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (bus.mem_resp_valid) begin
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
            if (bus.mem_req_valid && rq_rdy) begin
                mem_addr_q.push_back(bus.mem_req_addr);
                mem_due_q.push_back(cycle + mem_lat);
                hs_count++;
            end
        end
        cycle++;
    endtask

    initial begin
        int  first;
        bit  found;
        logic [31:0] rpc;
        reset              = 1'b1;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.deq_ready      = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;

        // Streaming with single-cycle memory: one request and one instruction per cycle.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        cmp("reset_req_valid", 32'(bus.mem_req_valid), 32'h0);
        cmp("reset_deq_valid", 32'(bus.deq_valid), 32'h0);
        first = BYP ? 1 : 2;
        for (int k = 0; k < 22; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (k < 20) cmp("A_req_addr", bus.mem_req_addr, 32'(4 * k));
            if (k == 0) cmp("A_first_deq_valid", 32'(bus.deq_valid), 32'h0);
            if (k >= first && (k - first) <= 16) begin
                cmp("A_deq_pc_plus4", bus.deq_pc_plus4, 32'(4 * (k - first) + 4));
                if ((k - first) == 16) cmp("A_inst_at_0x40", bus.deq_inst, 32'h2402_0005);
            end
        end

        // Stalled fetch stage: credits stop issue at DEPTH, then drain in order and resume at 0x10.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        hs_count = 0;
        for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("B_issued", 32'(hs_count), 32'd4);
        cmp("B_req_valid_full", 32'(bus.mem_req_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            cmp("B_drain_pc_plus4", bus.deq_pc_plus4, 32'(4 * i + 4));
            if (i == 1) begin
                cmp("B_resume_valid", 32'(bus.mem_req_valid), 32'h1);
                cmp("B_resume_addr", bus.mem_req_addr, 32'h10);
            end
        end

        // Three-cycle memory, three reads in flight, redirect to 0x100 discards them.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        mem_lat = 3;
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            cmp("C_req_addr", bus.mem_req_addr, 32'h20 + 32'(4 * k));
        end
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        cmp("C_redirect_req_valid", 32'(bus.mem_req_valid), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cmp("C_after_redirect_deq_valid", 32'(bus.deq_valid), 32'h0);
        cmp("C_after_redirect_addr", bus.mem_req_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (bus.deq_valid) begin
                found = 1'b1;
                cmp("C_target_pc_plus4", bus.deq_pc_plus4, 32'h104);
                cmp("C_target_inst", bus.deq_inst, mem_word(32'h100));
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("[TB] FAIL C_target_timeout: got no deq_valid expected entry for 0x100 within 30 cycles");
        end

        // Fill while stalled, then redirect with a dequeue attempt: nothing stale may surface.
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cmp("D_post_redirect_deq_valid", 32'(bus.deq_valid), 32'h0);
        cmp("D_post_redirect_addr", bus.mem_req_addr, 32'h200);

        // Reset with words both buffered and in flight.
        mem_lat = 2;
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cmp("E_reset_deq_valid", 32'(bus.deq_valid), 32'h0);
        cmp("E_reset_addr", bus.mem_req_addr, RESET_PC);
        cmp("E_reset_req_valid", 32'(bus.mem_req_valid), 32'h1);

        // Random traffic against the model.
        mem_stall_en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) mem_lat = $urandom_range(1, 4);
            rpc = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0)  rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) rpc = 32'hFFFF_FFF8;
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, rpc,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
